// File: rtl/byte_stream_aligner.sv
// Packet byte-stream aligner: drops a per-packet leading byte offset and repacks
// the remaining bytes into full output beats, with a shortened final beat.
module byte_stream_aligner #(
  parameter int DATA_BYTES = 16,
  parameter int OFF_W      = $clog2(DATA_BYTES),
  parameter int CNT_W      = $clog2(DATA_BYTES) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_BYTES*8-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [OFF_W-1:0]        s_offset,
  input  logic [CNT_W-1:0]        s_bytes,
  output logic [DATA_BYTES*8-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [CNT_W-1:0]        m_bytes,
  output logic                    drop_pulse
);

  localparam int W = DATA_BYTES * 8;
  localparam logic [CNT_W-1:0] N_C = CNT_W'(DATA_BYTES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Out-of-range byte counts (0 or above a full beat) mean a full beat.
  function automatic logic [CNT_W-1:0] sat_bytes(input logic [CNT_W-1:0] b);
    if (b == '0 || b > N_C) return N_C;
    return b;
  endfunction

  function automatic logic [W-1:0] keep_low(input logic [W-1:0] d, input logic [CNT_W-1:0] n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (CNT_W'(i) < n) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  logic [1:0]       state_p0;
  logic [W-1:0]     res_p0;
  logic [OFF_W-1:0] off_p0;
  logic [CNT_W-1:0] tail_p0;
  logic [W-1:0]     data_p0;
  logic             last_p0;
  logic [CNT_W-1:0] bytes_p0;
  logic             vld_p0;
  logic             drop_p0;

  logic             out_free;
  logic             acc;
  logic [CNT_W-1:0] in_bytes;
  logic [CNT_W-1:0] off_ext;
  logic [CNT_W-1:0] in_off_ext;
  logic [CNT_W-1:0] up_bytes;
  logic [W-1:0]     head;

  logic             ld;
  logic [W-1:0]     ld_data;
  logic             ld_last;
  logic [CNT_W-1:0] ld_bytes;
  logic [1:0]       nxt_state;
  logic [W-1:0]     nxt_res;
  logic [OFF_W-1:0] nxt_off;
  logic [CNT_W-1:0] nxt_tail;
  logic             nxt_drop;

  assign out_free   = !vld_p0 || m_ready;
  assign s_ready    = out_free && (state_p0 != ST_FLUSH);
  assign acc        = s_valid && s_ready;
  assign in_bytes   = sat_bytes(s_bytes);
  assign off_ext    = CNT_W'(off_p0);
  assign in_off_ext = CNT_W'(s_offset);
  // The new beat's low bytes land just above the residual's surviving N-o bytes.
  assign up_bytes   = N_C - off_ext;
  assign head       = res_p0 >> {off_p0, 3'b000};

  always_comb begin
    ld        = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    ld_bytes  = '0;
    nxt_state = state_p0;
    nxt_res   = res_p0;
    nxt_off   = off_p0;
    nxt_tail  = tail_p0;
    nxt_drop  = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        if (acc) begin
          nxt_off = s_offset;
          nxt_res = s_data;
          if (s_last) begin
            if (in_bytes > in_off_ext) begin
              ld       = 1'b1;
              ld_data  = keep_low(s_data, in_bytes) >> {s_offset, 3'b000};
              ld_bytes = in_bytes - in_off_ext;
              ld_last  = 1'b1;
            end else begin
              nxt_drop = 1'b1;
            end
          end else begin
            nxt_state = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (acc) begin
          ld = 1'b1;
          if (!s_last || in_bytes > off_ext) begin
            ld_data  = head | (s_data << {up_bytes, 3'b000});
            ld_bytes = N_C;
            nxt_res  = s_data;
            if (s_last) begin
              nxt_tail  = in_bytes - off_ext;
              nxt_state = ST_FLUSH;
            end
          end else begin
            ld_data   = head | (keep_low(s_data, in_bytes) << {up_bytes, 3'b000});
            ld_bytes  = up_bytes + in_bytes;
            ld_last   = 1'b1;
            nxt_state = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          ld        = 1'b1;
          ld_data   = keep_low(head, tail_p0);
          ld_bytes  = tail_p0;
          ld_last   = 1'b1;
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Stage p0: residual/offset state and registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      res_p0   <= '0;
      off_p0   <= '0;
      tail_p0  <= '0;
      data_p0  <= '0;
      last_p0  <= 1'b0;
      bytes_p0 <= '0;
      vld_p0   <= 1'b0;
      drop_p0  <= 1'b0;
    end else begin
      state_p0 <= nxt_state;
      res_p0   <= nxt_res;
      off_p0   <= nxt_off;
      tail_p0  <= nxt_tail;
      drop_p0  <= nxt_drop;
      if (ld) begin
        vld_p0   <= 1'b1;
        data_p0  <= ld_data;
        last_p0  <= ld_last;
        bytes_p0 <= ld_bytes;
      end else if (m_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign m_data     = data_p0;
  assign m_valid    = vld_p0;
  assign m_last     = last_p0;
  assign m_bytes    = bytes_p0;
  assign drop_pulse = drop_p0;

endmodule
